cla_addsub_pipe: RTL and testbench



---
 rtl/cla_addsub_pipe.sv | 169 ++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_SAT_EN to clamp overflowing results to the signed extreme instead of wrapping.
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             COUT,
    output logic             OVF,
    output logic             ZF
);

    localparam int NG = WIDTH / 4;

    // The group equations below are hand-expanded for 4-bit groups only.
    if (GRP != 4) begin : g_bad_grp
        $fatal(1, "cla_addsub_pipe: GRP must be 4");
    end
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $fatal(1, "cla_addsub_pipe: WIDTH must be a multiple of 4 and at least 8");
    end

    logic             s1Valid_q;
    logic [WIDTH-1:0] hBits_q;
    logic [WIDTH-1:0] gBits_q;
    logic [WIDTH-1:0] pBits_q;
    logic [NG-1:0]    grpGen_q;
    logic [NG-1:0]    grpProp_q;
    logic             carryIn_q;
    logic             aMsb_q;
    logic             bxMsb_q;

    logic             s2Valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zf_q;

    logic             s2Advance;

    logic [WIDTH-1:0] bx;
    logic             carryIn_d;
    logic [WIDTH-1:0] hBits_d;
    logic [WIDTH-1:0] gBits_d;
    logic [WIDTH-1:0] pBits_d;
    logic [NG-1:0]    grpGen_d;
    logic [NG-1:0]    grpProp_d;

    logic [NG:0]      grpCarry;
    logic [WIDTH-1:0] bitCarry;
    logic [WIDTH-1:0] sumRaw;
    logic [WIDTH-1:0] result_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zf_d;

    assign s2Advance = ~s2Valid_q | out_ready;
    assign in_ready  = ~s1Valid_q | s2Advance;

    // Subtraction is A + ~B + 1, so the carry-in is forced high and CIN ignored.
    assign bx        = SUB ? ~B : B;
    assign carryIn_d = SUB ? 1'b1 : CIN;
    assign gBits_d   = A & bx;
    assign pBits_d   = A | bx;
    assign hBits_d   = A ^ bx;

    for (genvar k = 0; k < NG; k++) begin : g_grp_terms
        localparam int B0 = 4 * k;
        assign grpGen_d[k]  = gBits_d[B0+3]
                            | (pBits_d[B0+3] & gBits_d[B0+2])
                            | (pBits_d[B0+3] & pBits_d[B0+2] & gBits_d[B0+1])
                            | (pBits_d[B0+3] & pBits_d[B0+2] & pBits_d[B0+1] & gBits_d[B0]);
        assign grpProp_d[k] = &pBits_d[B0 +: 4];
    end

    // Stage 1 only moves when stage 2 can take its current beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            hBits_q   <= '0;
            gBits_q   <= '0;
            pBits_q   <= '0;
            grpGen_q  <= '0;
            grpProp_q <= '0;
            carryIn_q <= 1'b0;
            aMsb_q    <= 1'b0;
            bxMsb_q   <= 1'b0;
        end else if (in_ready) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                hBits_q   <= hBits_d;
                gBits_q   <= gBits_d;
                pBits_q   <= pBits_d;
                grpGen_q  <= grpGen_d;
                grpProp_q <= grpProp_d;
                carryIn_q <= carryIn_d;
                aMsb_q    <= A[WIDTH-1];
                bxMsb_q   <= bx[WIDTH-1];
            end
        end
    end

    assign grpCarry[0] = carryIn_q;

    for (genvar k = 0; k < NG; k++) begin : g_carries
        localparam int B0 = 4 * k;
        assign grpCarry[k+1]  = grpGen_q[k] | (grpProp_q[k] & grpCarry[k]);
        assign bitCarry[B0]   = grpCarry[k];
        assign bitCarry[B0+1] = gBits_q[B0]
                              | (pBits_q[B0] & grpCarry[k]);
        assign bitCarry[B0+2] = gBits_q[B0+1]
                              | (pBits_q[B0+1] & gBits_q[B0])
                              | (pBits_q[B0+1] & pBits_q[B0] & grpCarry[k]);
        assign bitCarry[B0+3] = gBits_q[B0+2]
                              | (pBits_q[B0+2] & gBits_q[B0+1])
                              | (pBits_q[B0+2] & pBits_q[B0+1] & gBits_q[B0])
                              | (pBits_q[B0+2] & pBits_q[B0+1] & pBits_q[B0] & grpCarry[k]);
    end

    assign sumRaw = hBits_q ^ bitCarry;
    assign cout_d = grpCarry[NG];
    assign ovf_d  = (aMsb_q == bxMsb_q) & (sumRaw[WIDTH-1] != aMsb_q);

`ifdef CLA_SAT_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    assign result_d = ovf_d ? (aMsb_q ? MOST_NEG : MOST_POS) : sumRaw;
`else
    assign result_d = sumRaw;
`endif

    assign zf_d = ~|result_d;

    // Result registers load only when a real beat enters stage 2, so bubbles keep the last F.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zf_q      <= 1'b0;
        end else if (s2Advance) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                result_q <= result_d;
                cout_q   <= cout_d;
                ovf_q    <= ovf_d;
                zf_q     <= zf_d;
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign F         = result_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;
    assign ZF        = zf_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed testbench for cla_addsub_pipe (WIDTH=32): arithmetic cases, backpressure, mid-flight reset.
module tb_cla_addsub_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        CIN;
    logic        SUB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] F;
    logic        COUT;
    logic        OVF;
    logic        ZF;

    int checks;
    int errors;
    int beatIdx;
    int outIdx;

    cla_addsub_pipe #(.WIDTH(32), .GRP(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .CIN      (CIN),
        .SUB      (SUB),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .F        (F),
        .COUT     (COUT),
        .OVF      (OVF),
        .ZF       (ZF)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One beat in, then confirm the result appears exactly two edges later.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input logic [31:0] expF,
                                 input logic expC, input logic expO, input logic expZ);
        @(negedge clk);
        A = a; B = b; CIN = cin; SUB = sub; in_valid = 1'b1;
        #1 checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 checkOutput({tag, ".early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".F"},     F,              expF);
        checkOutput({tag, ".COUT"},  32'(COUT),      32'(expC));
        checkOutput({tag, ".OVF"},   32'(OVF),       32'(expO));
        checkOutput({tag, ".ZF"},    32'(ZF),        32'(expZ));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        CIN       = 1'b0;
        SUB       = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        #1;
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.F",         F,              32'd0);
        checkOutput("rst.COUT",      32'(COUT),      32'd0);
        checkOutput("rst.OVF",       32'(OVF),       32'd0);
        checkOutput("rst.ZF",        32'(ZF),        32'd0);
        rst = 1'b0;
        #1 checkOutput("rst.in_ready", 32'(in_ready), 32'd1);

        applyStimulus("add_cin",  32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
        applyStimulus("ripple",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        applyStimulus("sub_brw",  32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        applyStimulus("sub_eq",   32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_SAT_EN
        applyStimulus("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        applyStimulus("ovf_neg",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        applyStimulus("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        applyStimulus("ovf_neg",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif

        // Backpressure: beats k+k for k=1..4, downstream stalled in cycles 3-5.
        beatIdx = 0;
        outIdx  = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (beatIdx < 4);
            A         = 32'(beatIdx + 1);
            B         = 32'(beatIdx + 1);
            CIN       = 1'b0;
            SUB       = 1'b0;
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                checkOutput("bp.stall_in_ready",  32'(in_ready),  32'd0);
                checkOutput("bp.stall_out_valid", 32'(out_valid), 32'd1);
                checkOutput("bp.stall_F",         F,              32'd2);
            end
            if (cyc == 10) begin
                checkOutput("bp.bubble_valid", 32'(out_valid), 32'd0);
                checkOutput("bp.bubble_F",     F,              32'd8);
            end
            if (in_valid && in_ready) beatIdx++;
            if (out_valid && out_ready) begin
                checkOutput("bp.order", F, 32'(2 * (outIdx + 1)));
                outIdx++;
            end
        end
        in_valid = 1'b0;
        checkOutput("bp.beats_in",  32'(beatIdx), 32'd4);
        checkOutput("bp.beats_out", 32'(outIdx),  32'd4);

        // Fill both stages with downstream stalled, then reset mid-flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 32'd100; B = 32'd1; SUB = 1'b0; CIN = 1'b0;
        @(negedge clk);
        A = 32'd200;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("rmid.full_valid", 32'(out_valid), 32'd1);
        checkOutput("rmid.full_ready", 32'(in_ready),  32'd0);
        checkOutput("rmid.full_F",     F,              32'd101);
        rst = 1'b1;
        #1;
        checkOutput("rmid.async_valid", 32'(out_valid), 32'd0);
        checkOutput("rmid.async_F",     F,              32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1 checkOutput("rmid.post_valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 checkOutput("rmid.post_valid1", 32'(out_valid), 32'd0);
        applyStimulus("rmid.fresh", 32'd10, 32'd4, 1'b0, 1'b1, 32'd6, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
